// File: rtl/phase_sequencer.sv
// Execution phase sequencer: steps phases 1..LAST_PHASE per instruction, handles
// free-run / single-step / HLT, and keeps debug instruction and cycle counters.
module phase_sequencer #(
  parameter int LAST_PHASE = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic [15:0] instruction,
  output logic [2:0]  phase,
  output logic        running,
  output logic        halted,
  output logic        instr_done,
  output logic [15:0] instr_count,
  output logic [31:0] cycle_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [2:0] LAST = 3'(LAST_PHASE);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] phase_nxt;

  logic start_s;
  logic start_q;
  logic step_s;
  logic step_q;
  logic start_edge;
  logic step_edge;

  logic is_hlt;
  logic at_last;
  logic retire;

  logic unused_instr_bits;

  // Front-panel inputs are registered once, then compared with their previous
  // sample; an edge is therefore acted on one cycle after it is captured.
  assign start_edge = start_s & ~start_q;
  assign step_edge  = step_s & ~step_q;

  assign is_hlt  = (instruction[15:14] == 2'b11) && (instruction[7:4] == 4'b1111);
  assign at_last = (state == RUN) && (phase == LAST);
  assign retire  = at_last && !is_hlt;

  assign unused_instr_bits = ^{instruction[13:8], instruction[3:0]};

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        phase_nxt = 3'd0;
        if (start_edge) begin
          state_nxt = RUN;
          phase_nxt = 3'd1;
        end
      end
      RUN: begin
        if (phase == LAST) begin
          // HLT wins over step_mode so a halted program never lands in PAUSE.
          if (is_hlt) begin
            state_nxt = HALT;
            phase_nxt = 3'd0;
          end else if (step_mode) begin
            state_nxt = PAUSE;
            phase_nxt = 3'd0;
          end else begin
            phase_nxt = 3'd1;
          end
        end else begin
          phase_nxt = phase + 3'd1;
        end
      end
      PAUSE: begin
        phase_nxt = 3'd0;
        if (start_edge || step_edge) begin
          state_nxt = RUN;
          phase_nxt = 3'd1;
        end
      end
      HALT: begin
        phase_nxt = 3'd0;
        if (start_edge) begin
          state_nxt = RUN;
          phase_nxt = 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Loading the live inputs here means a level held through reset is not an edge.
      start_s     <= start;
      start_q     <= start;
      step_s      <= step;
      step_q      <= step;
      state       <= IDLE;
      phase       <= 3'd0;
      running     <= 1'b0;
      halted      <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= 16'd0;
      cycle_count <= 32'd0;
    end else begin
      start_s     <= start;
      start_q     <= start_s;
      step_s      <= step;
      step_q      <= step_s;
      state       <= state_nxt;
      phase       <= phase_nxt;
      running     <= (state_nxt == RUN);
      halted      <= (state_nxt == HALT);
      instr_done  <= (state_nxt == RUN) && (phase_nxt == LAST);
      if (retire) begin
        instr_count <= instr_count + 16'd1;
      end
      if ((phase != 3'd0) && (cycle_count != 32'hFFFF_FFFF)) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a vector table for reset/free-run/HLT plus
// hand-written sequences for stepping, mid-instruction changes, reset and counters.
module tb_phase_sequencer;

  localparam logic [15:0] ADD = 16'hC000;
  localparam logic [15:0] HLT = 16'hC0F0;

  logic        clk;
  logic        rst;
  logic        start;
  logic        step_mode;
  logic        step;
  logic [15:0] instruction;
  logic [2:0]  phase;
  logic        running;
  logic        halted;
  logic        instr_done;
  logic [15:0] instr_count;
  logic [31:0] cycle_count;

  int num_checks = 0;
  int num_errors = 0;
  int done_seen  = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        step_mode;
    logic        step;
    logic [15:0] instr;
    logic [2:0]  ph;
    logic        run;
    logic        hlt;
    logic        done;
    logic [15:0] ic;
    logic [31:0] cc;
  } vec_t;

  vec_t vecs[$];

  phase_sequencer #(.LAST_PHASE(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .instruction (instruction),
    .phase       (phase),
    .running     (running),
    .halted      (halted),
    .instr_done  (instr_done),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    start       = v.start;
    step_mode   = v.step_mode;
    step        = v.step;
    instruction = v.instr;
    tick();
  endtask

  task automatic doReset();
    rst   = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic ticksExpectPhase(input int n, input logic [2:0] first, input string name);
    logic [2:0] p;
    p = first;
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(name, 64'(phase), 64'(p));
      p = p + 3'd1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    step_mode   = 1'b0;
    step        = 1'b0;
    instruction = ADD;

    // Reset, free run of three ADDs, HLT, ignored step, resume from HALT.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ADD, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, ADD, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, ADD, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, ADD, 3'd1, 1'b1, 1'b0, 1'b0, 16'd0, 32'd0});
    for (int n = 1; n <= 19; n++) begin
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, (n >= 16) ? HLT : ADD,
                       3'((n % 5) + 1), 1'b1, 1'b0, ((n % 5) == 4),
                       16'(n / 5), 32'(n)});
    end
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, HLT, 3'd0, 1'b0, 1'b1, 1'b0, 16'd3, 32'd20});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, HLT, 3'd0, 1'b0, 1'b1, 1'b0, 16'd3, 32'd20});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, HLT, 3'd0, 1'b0, 1'b1, 1'b0, 16'd3, 32'd20});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, HLT, 3'd0, 1'b0, 1'b1, 1'b0, 16'd3, 32'd20});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, ADD, 3'd0, 1'b0, 1'b1, 1'b0, 16'd3, 32'd20});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, ADD, 3'd1, 1'b1, 1'b0, 1'b0, 16'd3, 32'd20});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, ADD, 3'd2, 1'b1, 1'b0, 1'b0, 16'd3, 32'd21});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (instr_done === 1'b1) done_seen++;
      checkOutput($sformatf("vec[%0d]", i),
                  {10'd0, phase, running, halted, instr_done, instr_count, cycle_count},
                  {10'd0, vecs[i].ph, vecs[i].run, vecs[i].hlt, vecs[i].done, vecs[i].ic, vecs[i].cc});
    end
    checkOutput("done_pulses", 64'(done_seen), 64'd4);

    // Single step: one instruction, then PAUSE with the cycle counter frozen.
    instruction = ADD;
    step_mode   = 1'b1;
    doReset();
    start = 1'b1;
    tick();
    checkOutput("ss_latency", 64'(phase), 64'd0);
    start = 1'b0;
    tick();
    checkOutput("ss_first", {61'd0, phase}, 64'd1);
    ticksExpectPhase(4, 3'd2, "ss_phase");
    for (int i = 0; i < 11; i++) begin
      tick();
      checkOutput("ss_pause_phase", {62'd0, running, phase != 3'd0}, 64'd0);
    end
    checkOutput("ss_cc_frozen", 64'(cycle_count), 64'd5);
    checkOutput("ss_ic1", 64'(instr_count), 64'd1);
    step = 1'b1;
    tick();
    checkOutput("ss_step_lat", 64'(phase), 64'd0);
    step = 1'b0;
    tick();
    checkOutput("ss_step_run", 64'(phase), 64'd1);
    ticksExpectPhase(4, 3'd2, "ss_phase2");
    tick();
    checkOutput("ss_ic2", {phase, 13'd0, instr_count, cycle_count}, {3'd0, 13'd0, 16'd2, 32'd10});
    step = 1'b1;
    tick();
    tick();
    checkOutput("ss_held_run", 64'(phase), 64'd1);
    ticksExpectPhase(4, 3'd2, "ss_phase3");
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("ss_held_pause", 64'(phase), 64'd0);
    end
    checkOutput("ss_held_counts", {16'd0, instr_count, cycle_count}, {16'd0, 16'd3, 32'd15});
    step = 1'b0;

    // step_mode raised at phase 2 only takes effect at the instruction boundary.
    step_mode = 1'b0;
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("sm_at2", 64'(phase), 64'd2);
    step_mode = 1'b1;
    ticksExpectPhase(3, 3'd3, "sm_finish");
    tick();
    checkOutput("sm_pause", {31'd0, running, 16'd0, instr_count}, {31'd0, 1'b0, 16'd0, 16'd1});
    step_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("sm_no_resume", {60'd0, running, phase}, 64'd0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    checkOutput("sm_resume", 64'(phase), 64'd1);
    ticksExpectPhase(4, 3'd2, "sm_phase");
    tick();
    checkOutput("sm_freerun", {44'd0, phase, running, instr_count}, {44'd0, 3'd1, 1'b1, 16'd2});

    // Reset at phase 3 aborts; start held through reset is not an edge.
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    checkOutput("rst_pre", {phase, 13'd0, instr_count, cycle_count}, {3'd3, 13'd0, 16'd1, 32'd7});
    rst   = 1'b1;
    start = 1'b1;
    tick();
    checkOutput("rst_abort", {12'd0, phase, running, instr_count, cycle_count}, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rst_held_start", {60'd0, running, phase}, 64'd0);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checkOutput("rst_fresh_lat", 64'(phase), 64'd0);
    start = 1'b0;
    tick();
    checkOutput("rst_fresh_run", {60'd0, running, phase}, {60'd0, 1'b1, 3'd1});

    // Counter boundaries via preloaded values.
    tick();
    tick();
    force dut.instr_count = 16'hFFFF;
    #1;
    release dut.instr_count;
    checkOutput("ic_preload", 64'(instr_count), 64'hFFFF);
    tick();
    tick();
    checkOutput("ic_last", {44'd0, phase, instr_done, instr_count}, {44'd0, 3'd5, 1'b1, 16'hFFFF});
    tick();
    checkOutput("ic_wrap", {45'd0, phase, instr_count}, {45'd0, 3'd1, 16'h0000});
    force dut.cycle_count = 32'hFFFF_FFFF;
    tick();
    tick();
    release dut.cycle_count;
    checkOutput("cc_max", 64'(cycle_count), 64'hFFFF_FFFF);
    tick();
    tick();
    checkOutput("cc_hold", {29'd0, phase, cycle_count}, {29'd0, 3'd5, 32'hFFFF_FFFF});

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Generates the 3-bit execution phase that drives the instruction decoder and datapath enables. The decoder treats phase 0 as "all enables off" and permits general-register write-back only in the last phase. This block steps phases 1..LAST_PHASE for each instruction and detects HLT at the last phase. It supports free-run and single-step modes from front-panel inputs, and keeps instruction and active-cycle counters for debug display.

## Interface
- LAST_PHASE, 5, final phase of an instruction (legal 2..7); phases run 1..LAST_PHASE.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  run request, level input; rising edge detected internally.
- step_mode  in  1  1 = pause after each instruction; 0 = free run.
- step  in  1  single-step request, level input; rising edge detected internally.
- instruction  in  16  current IR contents; HLT = instruction[15:14]==2'b11 and instruction[7:4]==4'b1111.
- phase  out  3  current phase; 0 = not executing.
- running  out  1  1 while state is RUN.
- halted  out  1  1 while state is HALT.
- instr_done  out  1  one-cycle pulse in the last phase of every completed instruction, including HLT.
- instr_count  out  16  count of completed non-HLT instructions; wraps.
- cycle_count  out  32  count of cycles with phase != 0; saturates at 32'hFFFF_FFFF.

## Operation
- States: IDLE, RUN, PAUSE, HALT. Reset state is IDLE.
- Edge detectors: start_q and step_q hold the previous input values. During reset they load the current input, so an input held high through reset produces no edge. An edge is input=1 with _q=0.
- IDLE: on a start edge, go to RUN with phase 1 on the next cycle. step edges are ignored.
- RUN: phase advances 1→2→…→LAST_PHASE, one per cycle. At phase==LAST_PHASE, instr_done=1 and the next state is chosen by this priority:
  - HLT instruction: go to HALT, phase 0. instr_count is unchanged.
  - Otherwise instr_count increments. If step_mode=1, go to PAUSE with phase 0. If step_mode=0, phase returns to 1 and the state stays RUN.
- step_mode is sampled only at phase==LAST_PHASE. Changing it mid-instruction has no effect until that boundary.
- PAUSE: on a step edge or a start edge, go to RUN with phase 1. If both occur in the same cycle, resume once.
- HALT: on a start edge, go to RUN with phase 1 (resume after HLT). step edges are ignored.
- start and step edges in RUN are ignored.
- instruction is sampled only in phase LAST_PHASE. Its value in other phases is don't-care.
- Outputs:
  - running = (state==RUN).
  - halted = (state==HALT).
  - phase = 0 in every state except RUN.
  - All outputs are registered; instr_done is a registered decode of the current phase.
- cycle_count increments on every clock where phase != 0 and the counter is not at max. At max it holds.
- instr_count wraps from 16'hFFFF to 0.

## Timing
- Reset values: phase=0, running=0, halted=0, instr_done=0, instr_count=0, cycle_count=0, state IDLE.
- rst takes priority over every other input in the same cycle. Asserting rst mid-instruction aborts it: phase=0 on the next edge, no count update.
- Start latency: a start edge sampled at edge t gives phase=1 and running=1 after edge t+1. Equivalently, phase 1 appears on the cycle after the edge is seen.
- Per-instruction cost in free run is exactly LAST_PHASE cycles, with no phase-0 bubble between instructions.
- In step mode, each instruction costs LAST_PHASE cycles plus at least one PAUSE cycle.
- instr_done is high exactly during the cycle where phase==LAST_PHASE.
- instr_count and the state/phase change take effect on the same edge that leaves phase LAST_PHASE.

## Test plan
- Reset then free run: rst=1 for 2 cycles, then a start pulse with step_mode=0 and instruction=16'hC000 (ADD).
  - Phase sequence is 0,1,2,3,4,5,1,2… with no 0 between instructions.
  - After 3 instructions, instr_count=3 and cycle_count=15.
  - instr_done has pulsed 3 times.
- HLT: run with instruction=16'hC0F0 (op=11, alu_op=1111).
  - After phase 5, phase=0 and halted=1.
  - instr_count is unchanged and instr_done pulsed once.
  - A start edge resumes with phase=1 one cycle later.
- Single step: step_mode=1, then start.
  - One instruction executes (phases 1–5), then phase holds at 0 in PAUSE for 10 cycles with cycle_count frozen at 5.
  - A step pulse gives phase=1 next cycle; instr_count=2 after that instruction.
  - A step held high gives only one instruction.
- step_mode toggled mid-instruction: free run, set step_mode=1 at phase 2.
  - The current instruction completes through phase 5, then PAUSE.
  - Clearing step_mode while in PAUSE does not resume; a step edge is required.
- Reset mid-operation and held inputs:
  - rst asserted at phase 3 gives phase=0 and counts=0 on the next edge.
  - start held high through and after reset does not start execution; only a fresh 0→1 does.
- Counter boundaries: preload by running 65535 non-HLT instructions (or force). The next completion wraps instr_count to 0. cycle_count forced to max holds at 32'hFFFF_FFFF.
